// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch front end.
package fetch_pkg;

  localparam int FETCH_PC_W  = 9;
  localparam int FETCH_INS_W = 32;
  localparam int FETCH_DEPTH = 4;

  // addi x0, x0, 0 -- decode substitutes this whenever id_valid is low
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch queue with single-cycle flush; storage is not reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = FETCH_DEPTH,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Upstream credit accounting makes both of these unreachable
  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && full && !flush));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && empty && !flush));

endmodule

// File: rtl/fetch_unit.sv
// PC generator, in-flight tracker and credit logic in front of the prefetch queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = FETCH_PC_W,
  parameter int              INS_W    = FETCH_INS_W,
  parameter int              DEPTH    = FETCH_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  localparam int             CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_en,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [PC_W-1:0]  id_pc,
  output logic [INS_W-1:0] id_instr,
  output logic [CNT_W-1:0] occupancy
);

  // Same layout as fetch_entry_t, but sized by this instance's parameters
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0]  fetch_pc_p0;
  logic             inflight_vld_p1;
  logic [PC_W-1:0]  inflight_pc_p1;
  logic             issue;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  entry_t           push_entry;
  entry_t           head;
  logic [CNT_W:0]   committed;
  logic [CNT_W:0]   limit;

  assign id_valid  = !fifo_empty;
  assign pop       = id_valid && id_ready && !redirect;
  assign push      = inflight_vld_p1 && !redirect;

  // count + inflight - pop < DEPTH, rearranged to stay unsigned
  assign committed = {1'b0, count} + (CNT_W + 1)'(inflight_vld_p1);
  assign limit     = (CNT_W + 1)'(DEPTH) + (CNT_W + 1)'(pop);
  assign issue     = !reset && !redirect && (committed < limit);

  assign imem_en   = issue;
  assign imem_addr = fetch_pc_p0;

  // p0 -> p1: address goes out to the synchronous instruction memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_p0     <= RESET_PC;
      inflight_vld_p1 <= 1'b0;
    end else if (redirect) begin
      fetch_pc_p0     <= redirect_pc;
      inflight_vld_p1 <= 1'b0;
    end else begin
      inflight_vld_p1 <= issue;
      if (issue) fetch_pc_p0 <= fetch_pc_p0 + PC_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) inflight_pc_p1 <= fetch_pc_p0;
  end

  // p1 -> queue: returning word is paired with the PC that requested it
  assign push_entry.pc    = inflight_pc_p1;
  assign push_entry.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign id_pc     = id_valid ? head.pc    : '0;
  assign id_instr  = id_valid ? head.instr : '0;
  assign occupancy = count;

  a_push_has_room: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule
